// File: rtl/mac_acc_pkg.sv
// mac_acc_pkg: shared definitions for the mac_acc accumulator slice.
//   - op encodings carried on in_op
//   - FSM state type for the read/drain controller
//   - OPV_W: width of the merged adder operand {co0+co1, s}
package mac_acc_pkg;

  localparam int unsigned OPV_W = 34;

  typedef enum logic [1:0] {
    MAC_ADD   = 2'b00,
    MAC_SUB   = 2'b01,
    MAC_LOAD  = 2'b10,
    MAC_LOADN = 2'b11
  } mac_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StOut
  } mac_state_e;

  // Operations that feed the accumulator with the negated operand.
  function automatic logic op_negates(input logic [1:0] op);
    return (op == MAC_SUB) || (op == MAC_LOADN);
  endfunction

  // Operations that overwrite the accumulator instead of adding to it.
  function automatic logic op_loads(input logic [1:0] op);
    return (op == MAC_LOAD) || (op == MAC_LOADN);
  endfunction

endpackage

// File: rtl/mac_acc_ext.sv
// mac_acc_ext: combinational operand builder.
//   Merges the two adder carry-outs (each weight 2^32) above the 32-bit sum,
//   zero-extends the 34-bit magnitude to ACC_W and negates it for SUB/LOADN.
// Ports:
//   op   in   2      operation code (mac_op_e encoding)
//   s    in   32     adder sum
//   co0  in   1      carry-out 0
//   co1  in   1      carry-out 1
//   opv  out  ACC_W  signed operand, modulo 2^ACC_W
module mac_acc_ext
  import mac_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic [1:0]       op,
  input  logic [31:0]      s,
  input  logic             co0,
  input  logic             co1,
  output logic [ACC_W-1:0] opv
);

  logic [1:0]       csum;
  logic [OPV_W-1:0] mag;
  logic [ACC_W-1:0] ext;

  assign csum = {1'b0, co0} + {1'b0, co1};
  assign mag  = {csum, s};
  assign ext  = {{(ACC_W - OPV_W){1'b0}}, mag};
  assign opv  = op_negates(op) ? -ext : ext;

endmodule

// File: rtl/mac_acc.sv
// mac_acc: wide signed accumulator behind the three-operand adder.
//   Beats {op, s, co0, co1} go through one operand register (p1) and are then
//   folded into acc. rd_req drains p1 and latches a stable snapshot that is
//   offered on a valid/ready port until consumed.
// Build option: define MAC_SAT_EN to clamp out_data to the signed 32-bit
//   range and report the clamp on ovf; otherwise out_data is acc[31:0] and
//   ovf is 0.
// Ports:
//   sys_clk, resetl             clock, async active-low reset
//   in_valid/in_ready           input beat handshake
//   in_op, in_s, in_co0, in_co1 beat payload
//   clr                         synchronous clear of acc and p1
//   rd_req                      request a drained snapshot
//   out_valid/out_ready         snapshot handshake
//   out_data, out_hi, ovf       snapshot low word, upper bits, clamp flag
module mac_acc
  import mac_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic              sys_clk,
  input  logic              resetl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [31:0]       in_s,
  input  logic              in_co0,
  input  logic              in_co1,
  input  logic              clr,
  input  logic              rd_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ACC_W-33:0] out_hi,
  output logic              ovf
);

  mac_state_e       state_q, state_d;
  logic             accept;
  logic             snap_en;
  logic [ACC_W-1:0] opv;

  logic             p1_v_q;
  logic             p1_load_q;
  logic [ACC_W-1:0] p1_opv_q;
  logic [ACC_W-1:0] acc_q;

  logic [31:0]       out_data_q;
  logic [ACC_W-33:0] out_hi_q;
  logic              ovf_q;

  logic [31:0] low_word;
  logic        low_ovf;

  // Gated by resetl so the port reads 0 during reset, not just after it.
  assign in_ready = resetl & ((state_q == StIdle) | (state_q == StRun)) & ~rd_req;
  assign accept   = in_valid & in_ready;

  mac_acc_ext #(
    .ACC_W(ACC_W)
  ) u_ext (
    .op (in_op),
    .s  (in_s),
    .co0(in_co0),
    .co1(in_co1),
    .opv(opv)
  );

  // Stage 1: operand register. A beat accepted alongside clr survives.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      p1_v_q    <= 1'b0;
      p1_load_q <= 1'b0;
      p1_opv_q  <= '0;
    end else begin
      p1_v_q <= accept;
      if (accept) begin
        p1_load_q <= op_loads(in_op);
        p1_opv_q  <= opv;
      end
    end
  end

  // Stage 2: accumulator, modulo 2^ACC_W. clr discards any beat already in p1.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (p1_v_q) begin
      acc_q <= p1_load_q ? p1_opv_q : acc_q + p1_opv_q;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    case (state_q)
      StIdle: begin
        if (rd_req) begin
          state_d = StDrain;
        end else if (accept) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (rd_req) begin
          state_d = StDrain;
        end else if (!accept && !p1_v_q) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (!p1_v_q) begin
          state_d = StOut;
          snap_en = 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MAC_SAT_EN
  logic [ACC_W-32:0] top_bits;
  logic              in_range;

  // acc fits in signed 32 bits iff bits [ACC_W-1:31] are all equal.
  assign top_bits = acc_q[ACC_W-1:31];
  assign in_range = (&top_bits) | ~(|top_bits);
  assign low_word = in_range ? acc_q[31:0] :
                    (acc_q[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  assign low_ovf  = ~in_range;
`else
  assign low_word = acc_q[31:0];
  assign low_ovf  = 1'b0;
`endif

  // Snapshot registers: written only on the DRAIN->OUT edge, so clr and
  // out_ready back-pressure leave them untouched.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      out_data_q <= '0;
      out_hi_q   <= '0;
      ovf_q      <= 1'b0;
    end else if (snap_en) begin
      out_data_q <= low_word;
      out_hi_q   <= acc_q[ACC_W-1:32];
      ovf_q      <= low_ovf;
    end
  end

  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign out_hi    = out_hi_q;
  assign ovf       = ovf_q;

endmodule
